// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared link definitions for the serial transmitter and receiver stages
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        GAP   = 3'd4
    } uart_state_e;

    localparam int DATA_BITS            = 8;
    localparam int FRAME_BITS           = 10;
    localparam int CLK_HZ               = 100_000_000;
    localparam int DEFAULT_CLKS_PER_BIT = 10_000_001;

    // Counter width able to hold 0..max(a,b)-1, never narrower than one bit.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/uart_frame_tx_if.sv
// rtl/uart_frame_tx_if.sv - byte handshake and serial line bundle for uart_frame_tx
interface uart_frame_tx_if
    import uart_pkg::*;
;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic                 tx_line;
    logic                 busy;

    modport master (output tx_data, tx_valid, input tx_ready, tx_line, busy);
    modport slave  (input tx_data, tx_valid, output tx_ready, tx_line, busy);
endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - small synchronous FIFO buffering bytes ahead of the serialiser
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

    // Next-state for storage and pointers.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_data;
            wr_ptr_d                = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // Storage and pointer registers, cleared to an empty FIFO on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end
endmodule

// File: rtl/uart_frame_tx.sv
// rtl/uart_frame_tx.sv - byte serialiser for the single-wire link; UART_TX_FIFO_EN adds an input FIFO
module uart_frame_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int GAP_CLKS     = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic            clk,
    input  logic            rst,
    uart_frame_tx_if.slave  bus
);
    localparam logic [2:0] S_IDLE  = IDLE;
    localparam logic [2:0] S_START = START;
    localparam logic [2:0] S_DATA  = DATA;
    localparam logic [2:0] S_STOP  = STOP;
    localparam logic [2:0] S_GAP   = GAP;
    localparam int         CNT_W   = cnt_width(CLKS_PER_BIT, GAP_CLKS);

    logic [2:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tx_line_q, tx_line_d;
    logic                 byte_avail;
    logic [DATA_BITS-1:0] byte_in;
    logic                 bit_done, gap_done;

`ifdef UART_TX_FIFO_EN
    logic                 fifo_full, fifo_empty, fifo_pop;
    logic [DATA_BITS-1:0] fifo_dout;

    assign fifo_pop = (state_q == S_IDLE) && !fifo_empty;

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_BITS)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (bus.tx_valid),
        .push_data (bus.tx_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign byte_avail   = !fifo_empty;
    assign byte_in      = fifo_dout;
    assign bus.tx_ready = !fifo_full;
    assign bus.busy     = (state_q != S_IDLE) || !fifo_empty;
`else
    logic unused_fifo_depth;
    assign unused_fifo_depth = (FIFO_DEPTH != 0);

    assign byte_avail   = bus.tx_valid;
    assign byte_in      = bus.tx_data;
    assign bus.tx_ready = (state_q == S_IDLE);
    assign bus.busy     = (state_q != S_IDLE);
`endif

    assign bit_done    = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
    assign gap_done    = (cnt_q == CNT_W'(GAP_CLKS - 1));
    assign bus.tx_line = tx_line_q;

    // Frame sequencer; the line level is derived from the next state so tx_line stays a flop.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        case (state_q)
            S_IDLE: begin
                if (byte_avail) begin
                    state_d   = S_START;
                    shift_d   = byte_in;
                    bit_idx_d = '0;
                    cnt_d     = '0;
                end
            end
            S_START: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    cnt_d     = '0;
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'(DATA_BITS - 1)) state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_GAP: begin
                if (gap_done) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        case (state_d)
            S_START: tx_line_d = 1'b1;
            S_DATA:  tx_line_d = shift_d[0];
            default: tx_line_d = 1'b0;
        endcase
    end

    // State registers; reset drops the line at once and abandons any partial frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_line_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_line_q <= tx_line_d;
        end
    end
endmodule
